// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: opcodes, ALU/writeback select encodings, the bubble
// instruction, and the ID/EX pipeline-register layout.
package rv32i_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_sel_t;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef struct packed {
        logic     reg_wen;
        logic     mem_rd;
        logic     mem_wr;
        logic     a_sel;
        logic     b_sel;
        logic     br_un;
        logic     branch;
        logic     jump;
        wb_sel_t  wb_sel;
        alu_sel_t alu_sel;
        logic     illegal;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
    } idex_t;

    // alt selects SUB/SRA; callers decide whether bit 30 is meaningful.
    function automatic alu_sel_t alu_from_funct(input logic [2:0] funct3, input logic alt);
        alu_sel_t sel;
        case (funct3)
            3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/id_pipeline_regfile.sv
// 32x32 integer register file: two asynchronous read ports with same-cycle
// write bypass, one synchronous write port, x0 hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);

    logic [31:0] regs [32];
    logic        wr_active;

    assign wr_active = wr_en && (wr_addr != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0)                    ? 32'd0   :
                      (wr_active && wr_addr == rs1_addr)    ? wr_data : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0)                    ? 32'd0   :
                      (wr_active && wr_addr == rs2_addr)    ? wr_data : regs[rs2_addr];

endmodule

// File: rtl/id_pipeline.sv
// RV32I decode stage: register read, immediate generation, control decode,
// load-use hazard detection and the ID/EX pipeline register.
module id_pipeline #(
    parameter logic [31:0] NOP_INST = rv32i_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pcPlus4_in,
    input  logic        flush_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_rd_in,
    input  logic [31:0] wb_data_in,
    output logic        stall_out,
    output logic [31:0] rs1_data_out,
    output logic [31:0] rs2_data_out,
    output logic [31:0] imm_out,
    output logic [31:0] pc_out,
    output logic [31:0] pcPlus4_out,
    output logic [4:0]  rd_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic [2:0]  funct3_out,
    output logic        RegWEn_out,
    output logic        MemRd_out,
    output logic        MemWr_out,
    output logic        ASel_out,
    output logic        BSel_out,
    output logic        BrUn_out,
    output logic        Branch_out,
    output logic        Jump_out,
    output logic [1:0]  WBSel_out,
    output logic [3:0]  ALUSel_out,
    output logic        illegal_out
);
    import rv32i_pkg::*;

    logic        legal;
    logic [31:0] inst;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic [2:0]  f3;
    logic [31:0] rs1_rd, rs2_rd;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic        uses_rs1, uses_rs2;
    idex_t       idex_next, idex;

    always_comb begin
        case (inst_in[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
    end

    // Unknown opcodes are decoded as the bubble instruction for all fields.
    assign inst  = legal ? inst_in : NOP_INST;
    assign rd_f  = inst[11:7];
    assign f3    = inst[14:12];
    assign rs1_f = inst[19:15];
    assign rs2_f = inst[24:20];

    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {inst[31:12], 12'b0};
    assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wb_en_in),
        .wr_addr  (wb_rd_in),
        .wr_data  (wb_data_in),
        .rs1_addr (rs1_f),
        .rs2_addr (rs2_f),
        .rs1_data (rs1_rd),
        .rs2_data (rs2_rd)
    );

    always_comb begin
        idex_next          = '0;
        uses_rs1           = 1'b0;
        uses_rs2           = 1'b0;
        idex_next.rs1_data = rs1_rd;
        idex_next.rs2_data = rs2_rd;
        idex_next.pc       = pc_in;
        idex_next.pc_plus4 = pcPlus4_in;
        idex_next.rd       = rd_f;
        idex_next.rs1      = rs1_f;
        idex_next.rs2      = rs2_f;
        idex_next.funct3   = f3;
        case (inst[6:0])
            OPC_LUI: begin
                idex_next.imm           = u_imm;
                idex_next.ctrl.reg_wen  = 1'b1;
                idex_next.ctrl.b_sel    = 1'b1;
                idex_next.ctrl.alu_sel  = ALU_PASSB;
                idex_next.ctrl.wb_sel   = WB_ALU;
            end
            OPC_AUIPC: begin
                idex_next.imm           = u_imm;
                idex_next.ctrl.reg_wen  = 1'b1;
                idex_next.ctrl.a_sel    = 1'b1;
                idex_next.ctrl.b_sel    = 1'b1;
                idex_next.ctrl.wb_sel   = WB_ALU;
            end
            OPC_JAL: begin
                idex_next.imm           = j_imm;
                idex_next.ctrl.reg_wen  = 1'b1;
                idex_next.ctrl.a_sel    = 1'b1;
                idex_next.ctrl.b_sel    = 1'b1;
                idex_next.ctrl.jump     = 1'b1;
                idex_next.ctrl.wb_sel   = WB_PC4;
            end
            OPC_JALR: begin
                idex_next.imm           = i_imm;
                idex_next.ctrl.reg_wen  = 1'b1;
                idex_next.ctrl.b_sel    = 1'b1;
                idex_next.ctrl.jump     = 1'b1;
                idex_next.ctrl.wb_sel   = WB_PC4;
                uses_rs1                = 1'b1;
            end
            OPC_BRANCH: begin
                idex_next.imm           = b_imm;
                idex_next.ctrl.a_sel    = 1'b1;
                idex_next.ctrl.b_sel    = 1'b1;
                idex_next.ctrl.branch   = 1'b1;
                idex_next.ctrl.br_un    = f3[2] & f3[1];
                uses_rs1                = 1'b1;
                uses_rs2                = 1'b1;
            end
            OPC_LOAD: begin
                idex_next.imm           = i_imm;
                idex_next.ctrl.reg_wen  = 1'b1;
                idex_next.ctrl.mem_rd   = 1'b1;
                idex_next.ctrl.b_sel    = 1'b1;
                idex_next.ctrl.wb_sel   = WB_MEM;
                uses_rs1                = 1'b1;
            end
            OPC_STORE: begin
                idex_next.imm           = s_imm;
                idex_next.ctrl.mem_wr   = 1'b1;
                idex_next.ctrl.b_sel    = 1'b1;
                uses_rs1                = 1'b1;
                uses_rs2                = 1'b1;
            end
            OPC_OP_IMM: begin
                // Bit 30 only distinguishes SRAI; for other funct3 it is immediate data.
                idex_next.imm           = i_imm;
                idex_next.ctrl.reg_wen  = 1'b1;
                idex_next.ctrl.b_sel    = 1'b1;
                idex_next.ctrl.alu_sel  = alu_from_funct(f3, inst[30] && (f3 == 3'b101));
                idex_next.ctrl.wb_sel   = WB_ALU;
                uses_rs1                = 1'b1;
            end
            OPC_OP: begin
                idex_next.ctrl.reg_wen  = 1'b1;
                idex_next.ctrl.alu_sel  = alu_from_funct(f3, inst[30]);
                idex_next.ctrl.wb_sel   = WB_ALU;
                uses_rs1                = 1'b1;
                uses_rs2                = 1'b1;
            end
            default: ;
        endcase
        if (!legal) begin
            idex_next.ctrl         = '0;
            idex_next.ctrl.illegal = 1'b1;
            uses_rs1               = 1'b0;
            uses_rs2               = 1'b0;
        end
    end

    // A flush kills the decoding instruction, so any hazard it carries is moot.
    assign stall_out = !reset && !flush_in && idex.ctrl.mem_rd && (idex.rd != 5'd0) &&
                       ((uses_rs1 && rs1_f == idex.rd) || (uses_rs2 && rs2_f == idex.rd));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex <= '0;
        end else if (flush_in || stall_out) begin
            idex <= '0;
        end else begin
            idex <= idex_next;
        end
    end

    assign rs1_data_out = idex.rs1_data;
    assign rs2_data_out = idex.rs2_data;
    assign imm_out      = idex.imm;
    assign pc_out       = idex.pc;
    assign pcPlus4_out  = idex.pc_plus4;
    assign rd_out       = idex.rd;
    assign rs1_out      = idex.rs1;
    assign rs2_out      = idex.rs2;
    assign funct3_out   = idex.funct3;
    assign RegWEn_out   = idex.ctrl.reg_wen;
    assign MemRd_out    = idex.ctrl.mem_rd;
    assign MemWr_out    = idex.ctrl.mem_wr;
    assign ASel_out     = idex.ctrl.a_sel;
    assign BSel_out     = idex.ctrl.b_sel;
    assign BrUn_out     = idex.ctrl.br_un;
    assign Branch_out   = idex.ctrl.branch;
    assign Jump_out     = idex.ctrl.jump;
    assign WBSel_out    = idex.ctrl.wb_sel;
    assign ALUSel_out   = idex.ctrl.alu_sel;
    assign illegal_out  = idex.ctrl.illegal;

endmodule

// File: doc/id_pipeline.md
ID_PIPELINE -- requirements
Module: id_pipeline

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0013, the encoding inserted as a bubble (addi x0,x0,0).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports inst_in, pc_in, pcPlus4_in  input  32 each  fetch-stage pipeline-register outputs.
REQ-005 SHALL have port flush_in  input  1  taken branch/jump resolved in EX (PCSel); kills the decoding instruction.
REQ-006 SHALL have ports wb_en_in (1), wb_rd_in (5), wb_data_in (32)  input  writeback write port.
REQ-007 SHALL have port stall_out  output  1  load-use hazard; fetch holds PC and the fetch pipeline register.
REQ-008 SHALL have ports rs1_data_out, rs2_data_out, imm_out, pc_out, pcPlus4_out  output  32 each  registered operands.
REQ-009 SHALL have ports rd_out, rs1_out, rs2_out (5 each), funct3_out (3)  output  registered fields.
REQ-010 SHALL have registered control outputs RegWEn_out, MemRd_out, MemWr_out, ASel_out, BSel_out, BrUn_out, Branch_out, Jump_out (1 each), WBSel_out (2), ALUSel_out (4), illegal_out (1).

Function
REQ-011 SHALL hold a 32x32 register file; x0 reads 0 always; writes to x0 ignored.
REQ-012 SHALL write wb_data_in to wb_rd_in on the clk edge when wb_en_in=1 and wb_rd_in!=0.
REQ-013 SHALL bypass same-cycle write to read: rs matching an active wb_rd_in (!=0) returns wb_data_in.
REQ-014 SHALL generate imm for I, S, B, U, J formats with sign extension from inst[31]; R-type imm=0.
REQ-015 SHALL decode opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP into control; ALUSel encodings SHALL come from the shared package.
REQ-016 SHALL treat any other opcode as NOP_INST control (all write/mem/branch enables 0) with illegal_out=1 in EX.
REQ-017 SHALL latch all outputs into the ID/EX register each cycle; latency inst_in -> outputs exactly 1 cycle.
REQ-018 SHALL assert stall_out combinationally when MemRd_out=1, rd_out!=0, and rd_out equals a source register the current instruction uses (rs1 and/or rs2 per format).
REQ-019 SHALL, on stall, load a bubble (all enables 0, rd_out=0, illegal_out=0) into ID/EX; operands don't-care but deterministic (zero).
REQ-020 SHALL, on flush_in=1, load a bubble and force stall_out=0; flush has priority over stall.
REQ-021 SHALL not block register-file writes during stall or flush.

Reset
REQ-022 SHALL, while reset=1, clear all 32 registers and drive every ID/EX output to 0 (bubble) asynchronously.
REQ-023 SHALL drive stall_out=0 during reset; first decode occurs on the first edge after reset deasserts.
REQ-024 SHALL, on reset mid-operation, discard in-flight state with no partial writeback.

Structure
REQ-025 SHALL take opcode constants, ALUSel and WBSel encodings, and NOP_INST from shared package rv32i_pkg.
REQ-026 SHALL instantiate one sub-module regfile (2 async read, 1 sync write, async reset); decode, imm-gen, hazard logic inline.

Verification
REQ-027 SHALL cover: wb x5=32'hDEAD_BEEF, then add x6,x5,x0 -> rs1_data_out=32'hDEAD_BEEF one cycle later.
REQ-028 SHALL cover: wb_en to x0 with 32'h1234 -> subsequent read of x0 = 0.
REQ-029 SHALL cover: lw x7,0(x1) then add x8,x7,x2 -> stall_out=1 one cycle, bubble in EX, add issued next cycle.
REQ-030 SHALL cover: same-cycle wb x9=32'h55 and decode of addi x10,x9,1 -> rs1_data_out=32'h55.
REQ-031 SHALL cover: flush_in=1 with load-use condition present -> stall_out=0, bubble in EX.
REQ-032 SHALL cover: beq imm -4096 and jal imm +1048574 -> imm_out 32'hFFFF_F000 and 32'h000F_FFFE; reset asserted mid-stream -> all outputs 0 immediately.
